// File: rtl/wishbone_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wishbone_arbiter_pkg;

  localparam int REG_BUS = 32;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_M0   = 2'b01,
    ARB_M1   = 2'b10
  } arb_state_t;

endpackage

// File: rtl/wishbone_arbiter_if.sv
// One Wishbone classic link: master drives request, slave returns data/ack.
interface wishbone_arbiter_if;
  import wishbone_arbiter_pkg::*;

  logic [REG_BUS-1:0] addr;
  logic [REG_BUS-1:0] wdata;
  logic [REG_BUS-1:0] rdata;
  logic               we;
  logic               stb;
  logic               cyc;
  logic [3:0]         sel;
  logic               ack;

  modport master (
    output addr, wdata, we, stb, cyc, sel,
    input  rdata, ack
  );

  modport slave (
    input  addr, wdata, we, stb, cyc, sel,
    output rdata, ack
  );

endinterface

// File: rtl/wishbone_arbiter_watchdog.sv
// Bus-timeout watchdog: counts cycles of an unanswered strobe and flags expiry.
module wishbone_arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic active,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] wd_cnt;

  // Expiry only fires while a strobe is outstanding; TIMEOUT of 0 disables it.
  always_comb begin
    expire = 1'b0;
    if ((TIMEOUT != 0) && active && (wd_cnt == LIMIT)) begin
      expire = 1'b1;
    end
  end

  // Count stalled cycles, restarting on any clear, idle strobe or expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= 16'd0;
    end else if (clr || !active || expire) begin
      wd_cnt <= 16'd0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant
// and a watchdog that forces an ack when the slave never answers.
module wishbone_arbiter
  import wishbone_arbiter_pkg::*;
#(
  parameter int                 TIMEOUT      = 16,
  parameter logic [REG_BUS-1:0] TIMEOUT_DATA = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  wishbone_arbiter_if.slave  m0,
  wishbone_arbiter_if.slave  m1,
  wishbone_arbiter_if.master s,
  output logic             timeout_o
);

  arb_state_t arb_state;
  arb_state_t next_state;
  logic       last_grant;
  logic       wd_active;
  logic       wd_clr;
  logic       wd_expire;
  logic       force_ack;

  // The watchdog only watches the strobe of whichever master owns the bus.
  assign wd_active = ((arb_state == ARB_M0) && m0.stb) ||
                     ((arb_state == ARB_M1) && m1.stb);
  assign wd_clr    = (next_state != arb_state) || s.ack;
  assign force_ack = wd_expire && !s.ack;
  assign timeout_o = force_ack;

  wishbone_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .active (wd_active),
    .expire (wd_expire)
  );

  // State register; last_grant records who most recently won the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_state  <= ARB_IDLE;
      last_grant <= 1'b1;
    end else begin
      arb_state <= next_state;
      if ((next_state == ARB_M0) && (arb_state != ARB_M0)) begin
        last_grant <= 1'b0;
      end else if ((next_state == ARB_M1) && (arb_state != ARB_M1)) begin
        last_grant <= 1'b1;
      end
    end
  end

  // Grant held for a whole cyc; on release hand straight to a waiting master.
  always_comb begin
    next_state = arb_state;
    case (arb_state)
      ARB_IDLE: begin
        if (m0.cyc && m1.cyc) begin
          next_state = last_grant ? ARB_M0 : ARB_M1;
        end else if (m0.cyc) begin
          next_state = ARB_M0;
        end else if (m1.cyc) begin
          next_state = ARB_M1;
        end
      end
      ARB_M0: begin
        if (!m0.cyc) begin
          next_state = m1.cyc ? ARB_M1 : ARB_IDLE;
        end
      end
      ARB_M1: begin
        if (!m1.cyc) begin
          next_state = m0.cyc ? ARB_M0 : ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // Route the owner to the slave and the slave's answer back to the owner;
  // a forced ack substitutes TIMEOUT_DATA and withdraws the slave strobe.
  always_comb begin
    s.addr   = ZERO_WORD;
    s.wdata  = ZERO_WORD;
    s.we     = 1'b0;
    s.stb    = 1'b0;
    s.cyc    = 1'b0;
    s.sel    = 4'h0;
    m0.rdata = ZERO_WORD;
    m0.ack   = 1'b0;
    m1.rdata = ZERO_WORD;
    m1.ack   = 1'b0;
    case (arb_state)
      ARB_M0: begin
        s.addr   = m0.addr;
        s.wdata  = m0.wdata;
        s.we     = m0.we;
        s.stb    = m0.stb;
        s.cyc    = m0.cyc;
        s.sel    = m0.sel;
        m0.rdata = s.rdata;
        m0.ack   = s.ack && m0.stb;
        if (force_ack) begin
          m0.ack   = 1'b1;
          m0.rdata = TIMEOUT_DATA;
          s.stb    = 1'b0;
          s.cyc    = 1'b0;
        end
      end
      ARB_M1: begin
        s.addr   = m1.addr;
        s.wdata  = m1.wdata;
        s.we     = m1.we;
        s.stb    = m1.stb;
        s.cyc    = m1.cyc;
        s.sel    = m1.sel;
        m1.rdata = s.rdata;
        m1.ack   = s.ack && m1.stb;
        if (force_ack) begin
          m1.ack   = 1'b1;
          m1.rdata = TIMEOUT_DATA;
          s.stb    = 1'b0;
          s.cyc    = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule
